// File: rtl/col_parity_ctrl_pkg.sv
// Shared definitions for the column-parity controller: FSM encoding and default geometry.
package col_parity_pkg;

  localparam int N_DEF = 6;
  localparam int W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } state_e;

  // RD and ACC together form the active part of a pass.
  function automatic logic is_busy(input state_e s);
    return (s == RD) || (s == ACC);
  endfunction

endpackage

// File: rtl/col_parity_ctrl_if.sv
// Control and memory-read bundle between the parity controller and its sequencer/memory.
interface col_parity_ctrl_if
  import col_parity_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) ();

  logic         start;
  logic         mem_rd;
  logic [N-1:0] mem_addr;
  logic [W-1:0] mem_data;
  logic [W-1:0] parity;
  logic         busy;
  logic         done;

  modport slave (
    input  start,
    input  mem_data,
    output mem_rd,
    output mem_addr,
    output parity,
    output busy,
    output done
  );

  modport master (
    output start,
    output mem_data,
    input  mem_rd,
    input  mem_addr,
    input  parity,
    input  busy,
    input  done
  );

endinterface

// File: rtl/col_parity_ctrl_counter.sv
// N-bit row-address counter with synchronous load, increment and all-ones carry-out.
module col_parity_ctrl_counter
  import col_parity_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [N-1:0] load_data_i,
  input  logic         inc_i,
  output logic [N-1:0] cnt_o,
  output logic         co_o
);

  logic [N-1:0] cnt_q;
  logic [N-1:0] cnt_d;

  // Load wins over increment so a new pass always starts from the load value.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_data_i;
    end else if (inc_i) begin
      cnt_d = cnt_q + N'(1);
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign co_o  = &cnt_q;

endmodule

// File: rtl/col_parity.sv
// Column-parity controller: walks all 2^N rows with sync reads and XOR-accumulates each column.
module col_parity_ctrl
  import col_parity_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  col_parity_ctrl_if.slave bus
);

  state_e       state_q;
  state_e       state_d;
  logic [W-1:0] acc_q;
  logic [W-1:0] acc_d;
  logic [N-1:0] row_addr;
  logic         last_row;
  logic         start_ok;
  logic         row_inc;

  // start only counts in IDLE; everywhere else it is ignored.
  assign start_ok = (state_q == IDLE) && bus.start;
  assign row_inc  = (state_q == ACC) && !last_row;

  col_parity_ctrl_counter #(
    .N (N)
  ) u_row_cnt (
    .clk         (clk),
    .rst_i       (~reset),
    .load_i      (start_ok),
    .load_data_i ({N{1'b0}}),
    .inc_i       (row_inc),
    .cnt_o       (row_addr),
    .co_o        (last_row)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d   = '0;
          state_d = RD;
        end
      end
      RD: begin
        state_d = ACC;
      end
      ACC: begin
        // Read data for the row issued in RD is present now.
        acc_d   = acc_q ^ bus.mem_data;
        state_d = last_row ? DONE : RD;
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
    end
  end

  assign bus.mem_rd   = (state_q == RD);
  assign bus.mem_addr = row_addr;
  assign bus.busy     = is_busy(state_q);
  assign bus.done     = (state_q == DONE);
  assign bus.parity   = acc_q;

endmodule

// File: tb/tb_col_parity_ctrl.sv
// Scoreboard bench for col_parity_ctrl with N=2, N=6 and N=1 instances sharing clock and reset.
module tb_col_parity_ctrl;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  col_parity_ctrl_if #(.N(2), .W(8)) b2 ();
  col_parity_ctrl_if #(.N(6), .W(8)) b6 ();
  col_parity_ctrl_if #(.N(1), .W(8)) b1 ();

  col_parity_ctrl #(.N(2), .W(8)) u_dut2 (.clk(clk), .reset(reset), .bus(b2.slave));
  col_parity_ctrl #(.N(6), .W(8)) u_dut6 (.clk(clk), .reset(reset), .bus(b6.slave));
  col_parity_ctrl #(.N(1), .W(8)) u_dut1 (.clk(clk), .reset(reset), .bus(b1.slave));

  logic [7:0] mem2 [4];
  logic [7:0] mem6 [64];
  logic [7:0] mem1 [2];

  // Sync-read memories; junk is driven whenever no read was issued.
  always @(posedge clk) begin
    b2.mem_data <= b2.mem_rd ? mem2[b2.mem_addr] : 8'($urandom);
    b6.mem_data <= b6.mem_rd ? mem6[b6.mem_addr] : 8'($urandom);
    b1.mem_data <= b1.mem_rd ? mem1[b1.mem_addr] : 8'($urandom);
  end

  typedef struct { int id; int cyc; int par; } done_t;
  typedef struct { int id; int addr; } rd_t;

  done_t dq[$];
  rd_t   aq[$];
  int    n_chk  = 0;
  int    n_pass = 0;
  bit    end_req = 1'b0;

  task automatic check(input string name, input int id, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h (cycle %0d)", name, id, act, exp, cyc);
  endtask

  task automatic fail_evt(input string name, input int id);
    n_chk++;
    $display("FAIL %s dut%0d: got an event, expected none (cycle %0d)", name, id, cyc);
  endtask

  task automatic rst_chk(input int id, input int busy, input int rd, input int done,
                         input int addr, input int par);
    check("rst_busy", id, busy, 0);
    check("rst_mem_rd", id, rd, 0);
    check("rst_done", id, done, 0);
    check("rst_mem_addr", id, addr, 0);
    check("rst_parity", id, par, 0);
  endtask

  task automatic mon(input int id, input bit done, input bit rd, input bit rise,
                     input int addr, input int par);
    if (rise) check("parity_clear", id, par, 0);
    if (rd) begin
      if (aq.size() == 0 || aq[0].id != id) fail_evt("unexpected_read", id);
      else begin
        rd_t r = aq.pop_front();
        check("mem_addr", id, addr, r.addr);
      end
    end
    if (done) begin
      if (dq.size() == 0 || dq[0].id != id) fail_evt("unexpected_done", id);
      else begin
        done_t e = dq.pop_front();
        check("done_cycle", id, cyc, e.cyc);
        check("parity", id, par, e.par);
      end
    end
  endtask

  // Monitor: pops expectations whenever a DUT presents a read or a done.
  initial begin
    bit pb2 = 1'b0, pb6 = 1'b0, pb1 = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        rst_chk(2, int'(b2.busy), int'(b2.mem_rd), int'(b2.done), int'(b2.mem_addr), int'(b2.parity));
        rst_chk(6, int'(b6.busy), int'(b6.mem_rd), int'(b6.done), int'(b6.mem_addr), int'(b6.parity));
        rst_chk(1, int'(b1.busy), int'(b1.mem_rd), int'(b1.done), int'(b1.mem_addr), int'(b1.parity));
        dq.delete();
        aq.delete();
        pb2 = 1'b0; pb6 = 1'b0; pb1 = 1'b0;
      end else begin
        while (dq.size() != 0 && cyc > dq[0].cyc) begin
          fail_evt("done_missing", dq[0].id);
          void'(dq.pop_front());
        end
        mon(2, b2.done, b2.mem_rd, b2.busy && !pb2, int'(b2.mem_addr), int'(b2.parity));
        mon(6, b6.done, b6.mem_rd, b6.busy && !pb6, int'(b6.mem_addr), int'(b6.parity));
        mon(1, b1.done, b1.mem_rd, b1.busy && !pb1, int'(b1.mem_addr), int'(b1.parity));
        pb2 = b2.busy; pb6 = b6.busy; pb1 = b1.busy;
      end
      if (end_req) begin
        check("pending_done", 0, dq.size(), 0);
        check("pending_reads", 0, aq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
      end
    end
  end

  task automatic set_start(input int id, input logic v);
    case (id)
      2:       b2.start = v;
      6:       b6.start = v;
      default: b1.start = v;
    endcase
  endtask

  task automatic push_pass(input int id, input int s, input int rows, input int par);
    dq.push_back('{id, s + 2 * rows + 1, par});
    for (int k = 0; k < rows; k++) aq.push_back('{id, k});
  endtask

  task automatic wait_idle(input int max_cyc);
    for (int i = 0; i < max_cyc && dq.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_pass(input int id, input int rows, input int par);
    push_pass(id, cyc, rows, par);
    set_start(id, 1'b1);
    @(negedge clk);
    set_start(id, 1'b0);
    wait_idle(2 * rows + 20);
  endtask

  initial begin
    int s;
    b2.start = 1'b0;
    b6.start = 1'b0;
    b1.start = 1'b0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Single pass, one bit per row.
    mem2 = '{8'h01, 8'h02, 8'h04, 8'h08};
    run_pass(2, 4, 8'h0F);

    mem2 = '{8'hFF, 8'hFF, 8'hFF, 8'h00};
    run_pass(2, 4, 8'hFF);
    mem2 = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_pass(2, 4, 8'h00);

    // start re-pulsed in cycle 3 and in DONE (9) is ignored; start in cycle 10 begins pass two.
    mem2 = '{8'h01, 8'h02, 8'h04, 8'h08};
    s = cyc;
    push_pass(2, s, 4, 8'h0F);
    b2.start = 1'b1;
    @(negedge clk);
    b2.start = 1'b0;
    while (cyc < s + 3) @(negedge clk);
    b2.start = 1'b1;
    @(negedge clk);
    b2.start = 1'b0;
    while (cyc < s + 9) @(negedge clk);
    b2.start = 1'b1;
    @(negedge clk);
    push_pass(2, s + 10, 4, 8'h0F);
    @(negedge clk);
    b2.start = 1'b0;
    wait_idle(40);

    // Asynchronous reset in the middle of cycle 5 of a pass.
    mem2 = '{8'h11, 8'h22, 8'h44, 8'h88};
    s = cyc;
    push_pass(2, s, 4, 8'hFF);
    b2.start = 1'b1;
    @(negedge clk);
    b2.start = 1'b0;
    while (cyc < s + 4) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);

    // start held high for 30 cycles: three back-to-back passes.
    mem2 = '{8'hA5, 8'h5A, 8'h00, 8'h00};
    s = cyc;
    push_pass(2, s, 4, 8'hFF);
    push_pass(2, s + 10, 4, 8'hFF);
    push_pass(2, s + 20, 4, 8'hFF);
    b2.start = 1'b1;
    repeat (30) @(negedge clk);
    b2.start = 1'b0;
    wait_idle(40);

    // Largest and smallest geometries.
    for (int i = 0; i < 64; i++) mem6[i] = 8'(i);
    run_pass(6, 64, 8'h00);
    mem1 = '{8'h3C, 8'h0F};
    run_pass(1, 2, 8'h33);

    end_req = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test, expected end before 200000 ns");
    $fatal(1, "simulation time limit");
  end

endmodule
